// File: rtl/tpu_pkg.sv
// Shared TPU definitions: feeder FSM states and default operand/array sizes.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } feeder_state_t;

  localparam int unsigned BITS_AB_DEFAULT = 8;
  localparam int unsigned DIM_DEFAULT     = 8;

  // Width of the beat counter: must hold 0..2*dim-2 and the value dim.
  function automatic int unsigned beat_width(input int unsigned dim);
    return $clog2(2 * dim - 1);
  endfunction

endpackage

// File: rtl/systolic_a_feeder_if.sv
// Write port, stream control and skewed operand outputs of the A-operand feeder.
interface systolic_a_feeder_if
  import tpu_pkg::*;
#(
  parameter int unsigned BITS_AB = BITS_AB_DEFAULT,
  parameter int unsigned DIM     = DIM_DEFAULT
) ();

  logic                     wr_en;
  logic [$clog2(DIM)-1:0]   wr_row;
  logic [DIM*BITS_AB-1:0]   wr_data;
  logic                     start;
  logic                     stall;
  logic [DIM*BITS_AB-1:0]   a_out;
  logic                     mac_en;
  logic                     busy;
  logic                     done;

  modport master (
    output wr_en, wr_row, wr_data, start, stall,
    input  a_out, mac_en, busy, done
  );

  modport slave (
    input  wr_en, wr_row, wr_data, start, stall,
    output a_out, mac_en, busy, done
  );

endinterface

// File: rtl/systolic_feed_row.sv
// One tile row: DIM-entry buffer with a full-row write port, and a skewed read
// that returns entry t-r for beat t on lane r, or zero outside the diagonal.
module systolic_feed_row
  import tpu_pkg::*;
#(
  parameter int unsigned BITS_AB = BITS_AB_DEFAULT,
  parameter int unsigned DIM     = DIM_DEFAULT,
  parameter int unsigned TW      = beat_width(DIM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DIM*BITS_AB-1:0] wr_data,
  input  logic [TW-1:0]          t,
  input  logic [TW-1:0]          r,
  output logic [BITS_AB-1:0]     entry
);

  localparam int unsigned IW = $clog2(DIM);

  logic [BITS_AB-1:0] mem [DIM];
  logic [TW-1:0]      col;

  // Row storage: cleared on reset, whole row replaced on a qualified write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < DIM; c++) mem[c] <= '0;
    end else if (wr_en) begin
      for (int unsigned c = 0; c < DIM; c++) mem[c] <= wr_data[c*BITS_AB +: BITS_AB];
    end
  end

  // Skewed read: column t-r when it lies inside the tile, zero padding otherwise.
  always_comb begin
    col   = t - r;
    entry = '0;
    if ((t >= r) && (col < TW'(DIM))) entry = mem[col[IW-1:0]];
  end

endmodule

// File: rtl/systolic_a_feeder.sv
// A-operand feeder: buffers a DIM x DIM tile and streams it as a diagonally
// skewed wavefront into the west edge of the MAC array, gating mac_en.
module systolic_a_feeder
  import tpu_pkg::*;
#(
  parameter int unsigned BITS_AB = BITS_AB_DEFAULT,
  parameter int unsigned DIM     = DIM_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  systolic_a_feeder_if.slave bus
);

  localparam int unsigned TW   = beat_width(DIM);
  localparam int unsigned RW   = $clog2(DIM);
  localparam logic [TW-1:0] LAST = TW'(2 * DIM - 2);

  feeder_state_t          state;
  logic [TW-1:0]          t;
  logic [TW-1:0]          beat_sel;
  logic [DIM*BITS_AB-1:0] next_beat;
  logic [DIM*BITS_AB-1:0] a_out_q;
  logic                   accept_wr;

  assign accept_wr = (state == IDLE) && bus.wr_en && !bus.start;

  // The rows are always presenting the beat that the next advancing edge
  // will load: beat 0 from IDLE, otherwise the one after the current beat.
  always_comb begin
    beat_sel = '0;
    if (state == STREAM) beat_sel = t + TW'(1);
  end

  for (genvar r = 0; r < DIM; r++) begin : g_row
    systolic_feed_row #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .TW      (TW)
    ) u_row (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (accept_wr && (bus.wr_row == RW'(r))),
      .wr_data (bus.wr_data),
      .t       (beat_sel),
      .r       (TW'(r)),
      .entry   (next_beat[r*BITS_AB +: BITS_AB])
    );
  end

  // Stream FSM with beat counter and registered operand lanes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      t       <= '0;
      a_out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= STREAM;
            t       <= '0;
            a_out_q <= next_beat;
          end
        end
        STREAM: begin
          if (!bus.stall) begin
            if (t == LAST) begin
              state   <= DONE;
              t       <= '0;
              a_out_q <= '0;
            end else begin
              t       <= t + TW'(1);
              a_out_q <= next_beat;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          t       <= '0;
          a_out_q <= '0;
        end
      endcase
    end
  end

  assign bus.a_out  = a_out_q;
  assign bus.mac_en = (state == STREAM) && !bus.stall;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_systolic_a_feeder.sv
// Self-checking bench for systolic_a_feeder at DIM=4, BITS_AB=8.
module tb_systolic_a_feeder;

  localparam int DIM = 4;
  localparam int BW  = 8;
  localparam int NB  = 2 * DIM - 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  systolic_a_feeder_if #(.BITS_AB(BW), .DIM(DIM)) bus ();

  systolic_a_feeder #(.BITS_AB(BW), .DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW-1:0]      mdl [DIM][DIM];
  logic [DIM*BW-1:0]  got [NB];

  typedef struct packed {
    logic [7:0] lane0;
    logic [7:0] lane3;
  } vec_t;

  vec_t tbl [NB];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference beat straight from the skew rule: lane r shows A[r][k-r].
  function automatic logic [DIM*BW-1:0] exp_beat(input int k);
    logic [DIM*BW-1:0] v;
    v = '0;
    for (int r = 0; r < DIM; r++) begin
      if (k - r >= 0 && k - r < DIM) v[r*BW +: BW] = mdl[r][k-r];
    end
    return v;
  endfunction

  task automatic write_row(input int r, input logic [DIM*BW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_row  = 2'(r);
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    for (int c = 0; c < DIM; c++) mdl[r][c] = d[c*BW +: BW];
  endtask

  task automatic load_base_tile();
    for (int r = 0; r < DIM; r++) begin
      logic [DIM*BW-1:0] d;
      for (int c = 0; c < DIM; c++) d[c*BW +: BW] = 8'(16 * r + c + 1);
      write_row(r, d);
    end
  endtask

  // Runs one stream and checks every cycle against the model. Stalls come
  // from a fixed window (stall_beat/stall_len) or at random; disturb pokes
  // start+write mid-stream, wr_with_start writes in the start cycle.
  task automatic stream_check(input string tag, input int stall_beat, input int stall_len,
                              input bit rnd, input bit disturb, input bit wr_with_start,
                              output int nst);
    int  k, cyc, st_run, stream_cyc;
    bit  stall, finished;
    k = 0; cyc = 0; st_run = 0; stream_cyc = 0; nst = 0; finished = 0;
    bus.start = 1'b1;
    if (wr_with_start) begin
      bus.wr_en = 1'b1; bus.wr_row = 2'd0; bus.wr_data = 32'h7F7F7F7F;
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.wr_en = 1'b0;
    for (int it = 0; it < 200; it++) begin
      if (k < NB) stall = rnd ? ($urandom_range(0, 3) == 0) : (k == stall_beat && st_run < stall_len);
      else        stall = 1'($urandom_range(0, 1));
      bus.stall = stall;
      if (disturb && k == 1) begin
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_row = 2'd0; bus.wr_data = 32'h7F7F7F7F;
      end
      #1;
      cyc++;
      if (k < NB) begin
        stream_cyc++;
        chk({tag, " a_out"}, bus.a_out, exp_beat(k));
        chk({tag, " mac_en"}, 32'(bus.mac_en), 32'(!stall));
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        chk({tag, " done_low"}, 32'(bus.done), 32'd0);
        if (!stall) got[k] = bus.a_out;
      end else begin
        chk({tag, " done_pulse"}, 32'(bus.done), 32'd1);
        chk({tag, " done_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, " done_mac_en"}, 32'(bus.mac_en), 32'd0);
        chk({tag, " done_a_out"}, bus.a_out, 32'd0);
      end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.wr_en = 1'b0; bus.stall = 1'b0;
      if (k == NB) begin
        finished = 1;
        break;
      end
      if (!stall) k++;
      else begin nst++; st_run++; end
    end
    chk({tag, " timeout"}, 32'(finished), 32'd1);
    chk({tag, " busy_cycles"}, 32'(cyc), 32'(2 * DIM + nst));
    chk({tag, " stream_cycles"}, 32'(stream_cyc), 32'(NB + nst));
    chk({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " idle_done"}, 32'(bus.done), 32'd0);
    chk({tag, " idle_mac_en"}, 32'(bus.mac_en), 32'd0);
  endtask

  initial begin
    int nst;

    tbl[0] = '{8'd1, 8'd0};
    tbl[1] = '{8'd2, 8'd0};
    tbl[2] = '{8'd3, 8'd0};
    tbl[3] = '{8'd4, 8'd49};
    tbl[4] = '{8'd0, 8'd50};
    tbl[5] = '{8'd0, 8'd51};
    tbl[6] = '{8'd0, 8'd52};

    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) mdl[r][c] = '0;

    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset a_out", bus.a_out, 32'd0);
    chk("reset mac_en", 32'(bus.mac_en), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Base tile, no stall, table-driven lane values.
    load_base_tile();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1;
      chk("tbl lane0", 32'(bus.a_out[0 +: BW]), 32'(tbl[i].lane0));
      chk("tbl lane3", 32'(bus.a_out[3*BW +: BW]), 32'(tbl[i].lane3));
      chk("tbl a_out", bus.a_out, exp_beat(i));
      chk("tbl mac_en", 32'(bus.mac_en), 32'd1);
      @(posedge clk); #1;
    end
    #1;
    chk("tbl done", 32'(bus.done), 32'd1);
    chk("tbl done_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk("tbl idle_done", 32'(bus.done), 32'd0);
    chk("tbl idle_busy", 32'(bus.busy), 32'd0);

    // Back-to-back restart of the same tile, then the stall window at beat 2.
    stream_check("restart", -1, 0, 0, 0, 0, nst);
    stream_check("stall3", 2, 3, 0, 0, 0, nst);
    chk("stall3 count", 32'(nst), 32'd3);

    // Negative operands keep their bit patterns on their own lanes.
    write_row(1, {8'h14, 8'h13, 8'h12, 8'h80});
    write_row(2, {8'hFF, 8'h23, 8'h22, 8'h21});
    stream_check("neg", -1, 0, 0, 0, 0, nst);
    chk("neg lane1 beat1", 32'(got[1][1*BW +: BW]), 32'h80);
    chk("neg lane0 beat1", 32'(got[1][0 +: BW]), 32'(mdl[0][1]));
    chk("neg lane2 beat5", 32'(got[5][2*BW +: BW]), 32'hFF);
    chk("neg lane3 beat5", 32'(got[5][3*BW +: BW]), 32'(mdl[3][2]));

    // Writes and start during STREAM are ignored; restart replays the tile.
    load_base_tile();
    stream_check("disturb", -1, 0, 0, 1, 0, nst);
    stream_check("after_disturb", -1, 0, 0, 0, 0, nst);

    // Write in the start cycle is dropped.
    stream_check("wr_start", -1, 0, 0, 0, 1, nst);
    stream_check("after_wr_start", -1, 0, 0, 0, 0, nst);

    // Reset at beat 3 aborts the stream and clears the buffer.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst beat3 a_out", bus.a_out, exp_beat(3));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst a_out", bus.a_out, 32'd0);
    chk("rst mac_en", 32'(bus.mac_en), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) mdl[r][c] = '0;
    @(posedge clk); #1;
    chk("rst no_done", 32'(bus.done), 32'd0);
    chk("rst still_idle", 32'(bus.busy), 32'd0);
    stream_check("zeros", -1, 0, 0, 0, 0, nst);

    // Random tiles and random stalls against the reference model.
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < DIM; r++) begin
        if ($urandom_range(0, 3) != 0) write_row(r, $urandom);
      end
      stream_check("rand", -1, 0, 1, 0, 0, nst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
